// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: FSM states, opcodes and the
// select/ALUOp codes understood by alu_decoder and the datapath muxes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic CAUSE_ILLEGAL     = 1'b0;
  localparam logic CAUSE_MEM_TIMEOUT = 1'b1;

endpackage

// File: rtl/instr_imm_decoder.sv
// Opcode to immediate-format select; purely combinational so the single-cycle
// main decoder can reuse it unchanged.
module instr_imm_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_immSrc
);

  always_comb begin
    o_immSrc = IMM_I;
    case (i_op)
      OP_SW:   o_immSrc = IMM_S;
      OP_BEQ:  o_immSrc = IMM_B;
      OP_JAL:  o_immSrc = IMM_J;
      default: o_immSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core, with a memory request/ready
// handshake, a watchdog on memory waits and a sticky trap state.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255,
  parameter int WD_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       trap,
  output logic       trap_cause
);

  // The watchdog fires on the wait cycle that would bring the count to the limit.
  localparam logic [WD_W-1:0] WD_LIMIT =
    (MEM_WAIT_MAX > 0) ? WD_W'(MEM_WAIT_MAX - 1) : '0;

  state_t          r_state;
  logic [WD_W-1:0] r_wdCount;
  logic            r_trap;
  logic            r_trapCause;

  state_t          w_nextState;
  logic            w_nextTrapCause;
  logic            w_inWait;
  logic            w_wdExpire;
  logic [WD_W-1:0] w_wdSat;
  logic [WD_W-1:0] w_wdCountNext;
  logic            w_memReq;
  logic            w_memWrite;
  logic            w_irWrite;
  logic            w_pcWrite;
  logic            w_regWrite;
  logic            w_instrDone;

  instr_imm_decoder u_immDecoder (
    .i_op     (op),
    .o_immSrc (ImmSrc)
  );

  assign w_inWait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                    (r_state == S_MEMWRITE);
  assign w_wdExpire = (MEM_WAIT_MAX != 0) && w_inWait && !mem_ready &&
                      (r_wdCount >= WD_LIMIT);
  assign w_wdSat = (&r_wdCount) ? r_wdCount : r_wdCount + 1'b1;
  assign w_wdCountNext = (w_inWait && !mem_ready && !w_wdExpire) ? w_wdSat : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_wdCount   <= '0;
      r_trap      <= 1'b0;
      r_trapCause <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_wdCount   <= w_wdCountNext;
      r_trap      <= (w_nextState == S_TRAP);
      r_trapCause <= w_nextTrapCause;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextTrapCause = r_trapCause;
    w_memReq        = 1'b0;
    w_memWrite      = 1'b0;
    w_irWrite       = 1'b0;
    w_pcWrite       = 1'b0;
    w_regWrite      = 1'b0;
    w_instrDone     = 1'b0;
    AdrSrc          = 1'b0;
    ResultSrc       = RES_ALUOUT;
    ALUSrcA         = SRCA_PC;
    ALUSrcB         = SRCB_RS2;
    ALUOp           = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_memReq  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_irWrite = mem_ready;
        w_pcWrite = mem_ready;
        if (mem_ready) w_nextState = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_R:         w_nextState = S_EXECUTER;
          OP_I:         w_nextState = S_EXECUTEI;
          OP_BEQ:       w_nextState = S_BEQ;
          OP_JAL:       w_nextState = S_JAL;
          default: begin
            w_nextState     = S_TRAP;
            w_nextTrapCause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_IMM;
        w_nextState = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_memReq = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) w_nextState = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
        w_nextState = S_FETCH;
      end
      S_MEMWRITE: begin
        w_memReq   = 1'b1;
        AdrSrc     = 1'b1;
        w_memWrite = 1'b1;
        if (mem_ready) begin
          w_instrDone = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_ALUWB: begin
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
        w_nextState = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_SUB;
        w_pcWrite   = Zero;
        w_instrDone = 1'b1;
        w_nextState = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pcWrite   = 1'b1;
        w_nextState = S_ALUWB;
      end
      S_TRAP: w_nextState = S_TRAP;
      default: w_nextState = S_FETCH;
    endcase
    // A stalled memory wait overrides whatever the state would otherwise do.
    if (w_wdExpire) begin
      w_nextState     = S_TRAP;
      w_nextTrapCause = CAUSE_MEM_TIMEOUT;
    end
  end

  assign mem_req    = w_memReq & rst;
  assign MemWrite   = w_memWrite & rst;
  assign IRWrite    = w_irWrite & rst;
  assign PCWrite    = w_pcWrite & rst;
  assign RegWrite   = w_regWrite & rst;
  assign instr_done = w_instrDone & rst;
  assign trap       = r_trap;
  assign trap_cause = r_trapCause;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: each instruction is expanded into per-cycle expected outputs
// from the step table and latency rules, then checked cycle by cycle.
module tb_multicycle_controller;

  localparam int WD_MAX = 4;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b0000000;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMREAD = 3;
  localparam int PH_MEMWB = 4, PH_MEMWRITE = 5, PH_EXECR = 6, PH_EXECI = 7;
  localparam int PH_ALUWB = 8, PH_BEQ = 9, PH_JAL = 10, PH_TRAP = 11;

  typedef struct packed {
    logic       memReq;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] immSrc;
    logic       instrDone;
    logic       trap;
    logic       trapCause;
  } out_t;

  typedef struct {
    logic       rstN;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    out_t       exp;
    int         ph;
    int         idx;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       instr_done, trap, trap_cause;
  out_t       act;

  cyc_t plan[$];
  cyc_t cur;
  bit   curValid = 1'b0;
  int   planIdx = 0;
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   lastDoneIdx = 0;
  int   irwCount = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .MEM_WAIT_MAX (WD_MAX),
    .WD_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  assign act = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, trap, trap_cause};

  function automatic string phName(input int ph);
    case (ph)
      PH_FETCH:    return "FETCH";
      PH_DECODE:   return "DECODE";
      PH_MEMADR:   return "MEMADR";
      PH_MEMREAD:  return "MEMREAD";
      PH_MEMWB:    return "MEMWB";
      PH_MEMWRITE: return "MEMWRITE";
      PH_EXECR:    return "EXECUTER";
      PH_EXECI:    return "EXECUTEI";
      PH_ALUWB:    return "ALUWB";
      PH_BEQ:      return "BEQ";
      PH_JAL:      return "JAL";
      default:     return "TRAP";
    endcase
  endfunction

  function automatic logic [1:0] immOf(input logic [6:0] o);
    case (o)
      T_SW:    return 2'b01;
      T_BEQ:   return 2'b10;
      T_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Output table per step; strobes vanish while reset is held low.
  function automatic out_t phaseOut(input int ph, input logic [6:0] o, input logic zero,
                                    input logic mr, input logic rstN, input logic cause);
    out_t r;
    r = '0;
    r.immSrc = immOf(o);
    case (ph)
      PH_FETCH: begin
        r.memReq = 1'b1; r.aluSrcB = 2'b10; r.resultSrc = 2'b10;
        r.irWrite = mr; r.pcWrite = mr;
      end
      PH_DECODE:   begin r.aluSrcA = 2'b01; r.aluSrcB = 2'b01; end
      PH_MEMADR:   begin r.aluSrcA = 2'b10; r.aluSrcB = 2'b01; end
      PH_MEMREAD:  begin r.memReq = 1'b1; r.adrSrc = 1'b1; end
      PH_MEMWB:    begin r.resultSrc = 2'b01; r.regWrite = 1'b1; r.instrDone = 1'b1; end
      PH_MEMWRITE: begin
        r.memReq = 1'b1; r.adrSrc = 1'b1; r.memWrite = 1'b1; r.instrDone = mr;
      end
      PH_EXECR:    begin r.aluSrcA = 2'b10; r.aluOp = 2'b10; end
      PH_EXECI:    begin r.aluSrcA = 2'b10; r.aluSrcB = 2'b01; r.aluOp = 2'b10; end
      PH_ALUWB:    begin r.regWrite = 1'b1; r.instrDone = 1'b1; end
      PH_BEQ: begin
        r.aluSrcA = 2'b10; r.aluOp = 2'b01; r.pcWrite = zero; r.instrDone = 1'b1;
      end
      PH_JAL:      begin r.aluSrcA = 2'b01; r.aluSrcB = 2'b10; r.pcWrite = 1'b1; end
      default:     begin r.trap = 1'b1; r.trapCause = cause; end
    endcase
    if (!rstN) begin
      r.memReq = 1'b0; r.memWrite = 1'b0; r.irWrite = 1'b0;
      r.pcWrite = 1'b0; r.regWrite = 1'b0; r.instrDone = 1'b0;
    end
    return r;
  endfunction

  task automatic addCycle(input int ph, input logic [6:0] o, input logic zero,
                          input logic mr, input logic rstN, input logic cause);
    cyc_t c;
    planIdx++;
    c.rstN = rstN; c.op = o; c.zero = zero; c.memReady = mr;
    c.exp = phaseOut(ph, o, zero, mr, rstN, cause);
    c.ph = ph; c.idx = planIdx;
    plan.push_back(c);
  endtask

  // Memory wait: the WD_MAX-th consecutive unready cycle is the last one before TRAP.
  task automatic planWait(input int ph, input logic [6:0] o, input logic zero,
                          input int waits, output bit trapped);
    trapped = 1'b0;
    for (int k = 1; k <= waits; k++) begin
      addCycle(ph, o, zero, 1'b0, 1'b1, 1'b0);
      if (WD_MAX != 0 && k >= WD_MAX) begin
        trapped = 1'b1;
        return;
      end
    end
    addCycle(ph, o, zero, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic planInstr(input logic [6:0] o, input logic zero, input int fWaits,
                           input int mWaits, input int trapHold);
    bit t;
    planIdx = 0;
    planWait(PH_FETCH, o, zero, fWaits, t);
    if (!t) begin
      addCycle(PH_DECODE, o, zero, 1'b1, 1'b1, 1'b0);
      case (o)
        T_R: begin
          addCycle(PH_EXECR, o, zero, 1'b1, 1'b1, 1'b0);
          addCycle(PH_ALUWB, o, zero, 1'b1, 1'b1, 1'b0);
        end
        T_I: begin
          addCycle(PH_EXECI, o, zero, 1'b1, 1'b1, 1'b0);
          addCycle(PH_ALUWB, o, zero, 1'b1, 1'b1, 1'b0);
        end
        T_LW: begin
          addCycle(PH_MEMADR, o, zero, 1'b1, 1'b1, 1'b0);
          planWait(PH_MEMREAD, o, zero, mWaits, t);
          if (!t) addCycle(PH_MEMWB, o, zero, 1'b1, 1'b1, 1'b0);
        end
        T_SW: begin
          addCycle(PH_MEMADR, o, zero, 1'b1, 1'b1, 1'b0);
          planWait(PH_MEMWRITE, o, zero, mWaits, t);
        end
        T_BEQ: addCycle(PH_BEQ, o, zero, 1'b1, 1'b1, 1'b0);
        T_JAL: begin
          addCycle(PH_JAL, o, zero, 1'b1, 1'b1, 1'b0);
          addCycle(PH_ALUWB, o, zero, 1'b1, 1'b1, 1'b0);
        end
        default: repeat (trapHold) addCycle(PH_TRAP, o, zero, 1'b0, 1'b1, 1'b0);
      endcase
    end
    if (t) repeat (trapHold) addCycle(PH_TRAP, o, zero, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic applyStimulus(input cyc_t c);
    @(posedge clk);
    #1;
    rst = c.rstN;
    op = c.op;
    Zero = c.zero;
    mem_ready = c.memReady;
    cur = c;
    curValid = 1'b1;
  endtask

  task automatic runPlan();
    while (plan.size() > 0) applyStimulus(plan.pop_front());
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input cyc_t c);
    checks++;
    if (act !== c.exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %05h expected %05h", phName(c.ph), c.idx,
               act, c.exp);
    end
    if (instr_done === 1'b1) begin
      doneCount++;
      lastDoneIdx = c.idx;
    end
    if (IRWrite === 1'b1) irwCount++;
  endtask

  task automatic checkLiteral(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (curValid) checkOutput(cur);
  end

  initial begin
    int d0;
    int i0;
    rst = 1'b0;
    op = T_R;
    Zero = 1'b0;
    mem_ready = 1'b1;

    $display("[TB] reset");
    planIdx = 0;
    addCycle(PH_FETCH, T_R, 1'b0, 1'b1, 1'b0, 1'b0);
    addCycle(PH_FETCH, T_R, 1'b0, 1'b1, 1'b0, 1'b0);
    runPlan();
    checkLiteral("reset trap", int'(trap), 0);

    $display("[TB] add");
    d0 = doneCount;
    planInstr(T_R, 1'b0, 0, 0, 0);
    runPlan();
    checkLiteral("add done pulses", doneCount - d0, 1);
    checkLiteral("add latency", lastDoneIdx, 4);

    $display("[TB] addi with two fetch waits");
    planInstr(T_I, 1'b0, 2, 0, 0);
    runPlan();
    checkLiteral("addi latency", lastDoneIdx, 6);

    $display("[TB] lw with three memread waits");
    planInstr(T_LW, 1'b0, 0, 3, 0);
    runPlan();
    checkLiteral("lw latency", lastDoneIdx, 8);

    $display("[TB] sw with one memwrite wait");
    planInstr(T_SW, 1'b0, 0, 1, 0);
    runPlan();
    checkLiteral("sw latency", lastDoneIdx, 5);

    $display("[TB] beq taken and not taken");
    planInstr(T_BEQ, 1'b1, 0, 0, 0);
    runPlan();
    checkLiteral("beq taken latency", lastDoneIdx, 3);
    planInstr(T_BEQ, 1'b0, 0, 0, 0);
    runPlan();
    checkLiteral("beq untaken latency", lastDoneIdx, 3);

    $display("[TB] jal");
    planInstr(T_JAL, 1'b0, 0, 0, 0);
    runPlan();
    checkLiteral("jal latency", lastDoneIdx, 4);

    $display("[TB] illegal opcode");
    d0 = doneCount;
    planInstr(T_BAD, 1'b0, 0, 0, 20);
    runPlan();
    checkLiteral("illegal done pulses", doneCount - d0, 0);
    checkLiteral("illegal trap", int'(trap), 1);
    checkLiteral("illegal cause", int'(trap_cause), 0);
    planIdx = 0;
    addCycle(PH_TRAP, T_BAD, 1'b0, 1'b0, 1'b0, 1'b0);
    runPlan();
    planInstr(T_R, 1'b0, 0, 0, 0);
    runPlan();
    checkLiteral("trap cleared", int'(trap), 0);
    checkLiteral("post-trap add latency", lastDoneIdx, 4);

    $display("[TB] fetch watchdog");
    i0 = irwCount;
    planInstr(T_R, 1'b0, 10, 0, 5);
    runPlan();
    checkLiteral("fetch timeout irwrite", irwCount - i0, 0);
    checkLiteral("fetch timeout cause", int'(trap_cause), 1);
    planIdx = 0;
    addCycle(PH_TRAP, T_R, 1'b0, 1'b0, 1'b0, 1'b1);
    runPlan();

    $display("[TB] memread watchdog");
    planInstr(T_LW, 1'b0, 0, 4, 3);
    runPlan();
    checkLiteral("memread timeout cause", int'(trap_cause), 1);
    planIdx = 0;
    addCycle(PH_TRAP, T_LW, 1'b0, 1'b0, 1'b0, 1'b1);
    runPlan();

    $display("[TB] reset during memwrite");
    d0 = doneCount;
    planIdx = 0;
    addCycle(PH_FETCH, T_SW, 1'b0, 1'b1, 1'b1, 1'b0);
    addCycle(PH_DECODE, T_SW, 1'b0, 1'b1, 1'b1, 1'b0);
    addCycle(PH_MEMADR, T_SW, 1'b0, 1'b1, 1'b1, 1'b0);
    addCycle(PH_MEMWRITE, T_SW, 1'b0, 1'b1, 1'b0, 1'b0);
    runPlan();
    checkLiteral("aborted sw done pulses", doneCount - d0, 0);
    planInstr(T_R, 1'b0, 0, 0, 0);
    runPlan();
    checkLiteral("add after abort latency", lastDoneIdx, 4);

    curValid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle variant of the RV32I core.
- Sequences one shared ALU, register file and unified memory through fetch/decode/execute/memory/writeback steps.
- Drives ALUOp into alu_decoder.
- Adds a memory request/ready handshake, a watchdog on memory waits, and a sticky trap for illegal opcodes.

Parameters:
MEM_WAIT_MAX, 255, max cycles held waiting for mem_ready before trapping; 0 disables the watchdog.
WD_W, 8, watchdog counter width; must hold MEM_WAIT_MAX.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-low reset
op  input  7  instruction[6:0] from instruction register
Zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
AdrSrc  output  1  0=PC, 1=ALUOut as memory address
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
PCWrite  output  1  PC load
RegWrite  output  1  register file write
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data
ALUSrcB  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
ALUOp  output  2  to alu_decoder: 00 add, 01 sub, 10 funct-decoded
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
instr_done  output  1  one-cycle pulse on an instruction's final state
trap  output  1  sticky fault indicator
trap_cause  output  1  0=illegal opcode, 1=memory timeout

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
- Outputs are Moore-decoded from state. Exceptions: PCWrite, IRWrite, MemWrite, instr_done also qualified by inputs, as stated below. Any output not listed for a state is 0.
- Reset:
  - rst low at posedge: state<=FETCH, watchdog<=0, trap<=0, trap_cause<=0.
  - While rst is low, mem_req, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0 combinationally, including mid-instruction.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready -> DECODE; else stay.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
  - Next state by op: lw 0000011 / sw 0100011 -> MEMADR; R 0110011 -> EXECUTER; I 0010011 -> EXECUTEI; beq 1100011 -> BEQ; jal 1101111 -> JAL.
  - Any other op -> TRAP with trap_cause=0.
- MEMADR:
  - Drives ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Drives mem_req=1, AdrSrc=1, ResultSrc=00.
  - mem_ready -> MEMWB; else stay.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
- MEMWRITE:
  - Drives mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1.
  - mem_ready -> FETCH with instr_done=1 that cycle.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
- BEQ:
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=Zero; instr_done=1 -> FETCH.
- JAL:
  - Drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - -> ALUWB (writes rd=PC+4); instr_done is asserted in ALUWB.
- TRAP:
  - All strobes 0, trap=1. Stays in TRAP until reset.
  - trap_cause is held from the cycle of entry.
- ImmSrc: combinational from op in every state. sw 01, beq 10, jal 11, all others 00.
- Watchdog:
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready=0; clears on mem_ready or on leaving those states.
  - If MEM_WAIT_MAX!=0 and count reaches MEM_WAIT_MAX with mem_ready still 0: -> TRAP, trap_cause=1, mem_req drops next cycle.
  - If mem_ready arrives in that same cycle, mem_ready wins.
  - Counter saturates and never wraps.
- Latencies at zero wait states: R/I 4 cycles, lw 5, sw 4, beq 3, jal 4.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings (shared with alu_decoder and the datapath).
- One natural sub-module: instr_imm_decoder, the combinational op->ImmSrc mapping, reusable by the single-cycle main decoder.

Test Plan:
- add x3,x1,x2 (op 0110011), mem_ready tied 1 -> states FETCH,DECODE,EXECUTER,ALUWB; ALUOp=10 in EXECUTER; RegWrite=1 and instr_done=1 in cycle 4 only.
- lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_req=1, AdrSrc=1 throughout, MEMWB follows; total 8 cycles.
- beq with Zero=1, then repeated with Zero=0 -> PCWrite=1 in BEQ only when Zero=1; ALUOp=01; back to FETCH after 3 cycles in both runs.
- op=0000000 in DECODE -> TRAP next cycle, trap=1, trap_cause=0; mem_req and all strobes stay 0 for 20 cycles; rst low for one edge -> FETCH, trap=0.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles with trap_cause=1; IRWrite never asserted.
- rst driven low during MEMWRITE with mem_ready=1 -> MemWrite=0 that cycle; FETCH on next cycle; no instr_done.
